// File: rtl/xbar_cfg_if.sv
// ---------------------------------------------------------------------------
// xbar_cfg_if
//   Bundles the routed data path and the shadow-bank configuration port of
//   xbar_cfg so the crossbar and its driver share one connection point.
//
//   Data path   : io_xbar_in (N_IN) -> io_xbar_out (N_OUT)
//   Config port : io_cfg_valid / io_cfg_ready / io_cfg_data handshake,
//                 io_cfg_commit strobe, io_cfg_full / io_cfg_err / io_cfg_idx
//                 status.
//
//   slave  : the crossbar side.
//   master : the tile routing / configuration controller side.
// ---------------------------------------------------------------------------
interface xbar_cfg_if #(
  parameter int N_IN  = 20,
  parameter int N_OUT = 25,
  parameter int SEL_W = 5,
  parameter int CNT_W = 5
);
  logic [N_IN-1:0]  io_xbar_in;
  logic [N_OUT-1:0] io_xbar_out;
  logic             io_cfg_valid;
  logic             io_cfg_ready;
  logic [SEL_W-1:0] io_cfg_data;
  logic             io_cfg_commit;
  logic             io_cfg_full;
  logic             io_cfg_err;
  logic [CNT_W-1:0] io_cfg_idx;

  modport slave (
    input  io_xbar_in, io_cfg_valid, io_cfg_data, io_cfg_commit,
    output io_xbar_out, io_cfg_ready, io_cfg_full, io_cfg_err, io_cfg_idx
  );

  modport master (
    output io_xbar_in, io_cfg_valid, io_cfg_data, io_cfg_commit,
    input  io_xbar_out, io_cfg_ready, io_cfg_full, io_cfg_err, io_cfg_idx
  );
endinterface

// File: rtl/xbar_cfg.sv
// ---------------------------------------------------------------------------
// xbar_cfg
//   Double-buffered N_IN x N_OUT routing crossbar. Each output k forwards
//   io_xbar_in[active[k]]; an out-of-range select drives 0. New selects are
//   loaded word-serially into a shadow bank and copied into the active bank
//   in a single edge by io_cfg_commit, so live traffic sees either the old
//   or the new routing, never a mix.
//
//   Ports:
//     clk    - rising-edge clock
//     reset  - asynchronous, active-low reset
//     bus    - xbar_cfg_if.slave (data path + configuration port)
//
//   Optional feature (macro XBAR_CFG_OUT_REG_EN):
//     defined   - io_xbar_out is registered (1-cycle data latency,
//                 commit-to-route 2 cycles).
//     undefined - io_xbar_out is purely combinational.
// ---------------------------------------------------------------------------
module xbar_cfg #(
  parameter int N_IN  = 20,
  parameter int N_OUT = 25,
  parameter int SEL_W = 5,
  parameter int CNT_W = 5
) (
  input logic         clk,
  input logic         reset,
  xbar_cfg_if.slave   bus
);

  typedef enum logic {
    S_LOAD = 1'b0,
    S_FULL = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_next_state;
  logic [SEL_W-1:0] r_shadow [N_OUT];
  logic [SEL_W-1:0] r_active [N_OUT];
  logic [CNT_W-1:0] r_idx;
  logic             r_err;

  logic             w_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_commit_ok;
  logic             w_commit_bad;
  logic [N_OUT-1:0] w_route;

  // Next-state and handshake decode.
  // NOTE: every signal gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    w_next_state = r_state;
    w_ready      = 1'b0;
    w_accept     = 1'b0;
    w_commit_ok  = 1'b0;
    w_commit_bad = 1'b0;
    w_last       = (r_idx == CNT_W'(N_OUT - 1));
    case (r_state)
      S_LOAD: begin
        w_ready      = 1'b1;
        w_accept     = bus.io_cfg_valid;
        // A commit before the bank is full is rejected; loading carries on.
        w_commit_bad = bus.io_cfg_commit;
        if (w_accept && w_last) w_next_state = S_FULL;
      end
      S_FULL: begin
        w_commit_ok = bus.io_cfg_commit;
        if (bus.io_cfg_commit) w_next_state = S_LOAD;
      end
      default: w_next_state = S_LOAD;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_LOAD;
    else        r_state <= w_next_state;
  end

  // Shadow/active banks, load index and error pulse.
  // NOTE: both banks are reset on purpose: routing must be defined (all
  // outputs follow input 0) straight out of reset and a partial load must be
  // discarded, so these are real flops rather than a RAM.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_idx <= '0;
      r_err <= 1'b0;
      for (int k = 0; k < N_OUT; k++) begin
        r_shadow[k] <= '0;
        r_active[k] <= '0;
      end
    end else begin
      r_err <= w_commit_bad;
      if (w_accept) begin
        r_shadow[r_idx] <= bus.io_cfg_data;
        r_idx           <= r_idx + CNT_W'(1);
      end
      if (w_commit_ok) begin
        // All fields copy on the same edge: the atomic swap.
        for (int k = 0; k < N_OUT; k++) r_active[k] <= r_shadow[k];
        r_idx <= '0;
      end
    end
  end

  // Routing mux: an explicit compare per legal input keeps out-of-range
  // selects at 0 instead of indexing past the input vector.
  always_comb begin
    w_route = '0;
    for (int k = 0; k < N_OUT; k++) begin
      for (int j = 0; j < N_IN; j++) begin
        if (r_active[k] == SEL_W'(j)) w_route[k] = bus.io_xbar_in[j];
      end
    end
  end

`ifdef XBAR_CFG_OUT_REG_EN
  logic [N_OUT-1:0] r_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_out <= '0;
    else        r_out <= w_route;
  end

  assign bus.io_xbar_out = r_out;
`else
  assign bus.io_xbar_out = w_route;
`endif

  assign bus.io_cfg_ready = w_ready;
  assign bus.io_cfg_full  = (r_state == S_FULL);
  assign bus.io_cfg_err   = r_err;
  assign bus.io_cfg_idx   = r_idx;

endmodule

// File: tb/tb_xbar_cfg.sv
// ---------------------------------------------------------------------------
// tb_xbar_cfg
//   Self-checking bench for xbar_cfg. A behavioural model (select arrays,
//   a load count and a full flag) predicts routing and status every cycle.
//   Follows XBAR_CFG_OUT_REG_EN when defined (registered output).
// ---------------------------------------------------------------------------
module tb_xbar_cfg;
  localparam int N_IN  = 20;
  localparam int N_OUT = 25;
  localparam int SEL_W = 5;
  localparam int CNT_W = 5;
  localparam int ST_W  = CNT_W + 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  xbar_cfg_if #(.N_IN(N_IN), .N_OUT(N_OUT), .SEL_W(SEL_W), .CNT_W(CNT_W)) bus ();

  xbar_cfg #(.N_IN(N_IN), .N_OUT(N_OUT), .SEL_W(SEL_W), .CNT_W(CNT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model.
  int               m_shadow [N_OUT];
  int               m_active [N_OUT];
  int               m_idx;
  bit               m_full;
  bit               m_err;
  logic [N_OUT-1:0] m_outq;

  function automatic logic [N_OUT-1:0] route(input logic [N_IN-1:0] xin);
    logic [N_OUT-1:0] r;
    for (int k = 0; k < N_OUT; k++)
      r[k] = (m_active[k] < N_IN) ? xin[m_active[k]] : 1'b0;
    return r;
  endfunction

  function automatic logic [N_OUT-1:0] exp_out();
`ifdef XBAR_CFG_OUT_REG_EN
    return m_outq;
`else
    return route(bus.io_xbar_in);
`endif
  endfunction

  function automatic logic [ST_W-1:0] exp_status();
    return {~m_full, m_full, m_err, CNT_W'(m_idx)};
  endfunction

  function automatic logic [ST_W-1:0] got_status();
    return {bus.io_cfg_ready, bus.io_cfg_full, bus.io_cfg_err, bus.io_cfg_idx};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N_OUT; k++) begin
      m_shadow[k] = 0;
      m_active[k] = 0;
    end
    m_idx  = 0;
    m_full = 1'b0;
    m_err  = 1'b0;
    m_outq = '0;
  endtask

  // One clock of stimulus; the model advances at the rising edge. The output
  // seen mid-cycle (before the edge) is returned for latency checks.
  task automatic drive_cycle(input bit v, input int d, input bit c,
                             input logic [N_IN-1:0] xin,
                             output logic [N_OUT-1:0] mid_got,
                             output logic [N_OUT-1:0] mid_exp);
    @(negedge clk);
    bus.io_cfg_valid  = v;
    bus.io_cfg_data   = SEL_W'(d);
    bus.io_cfg_commit = c;
    bus.io_xbar_in    = xin;
    #1;
    mid_got = bus.io_xbar_out;
    mid_exp = exp_out();
    @(posedge clk);
    m_outq = route(xin);
    m_err  = 1'b0;
    if (m_full) begin
      if (c) begin
        for (int k = 0; k < N_OUT; k++) m_active[k] = m_shadow[k];
        m_idx  = 0;
        m_full = 1'b0;
      end
    end else begin
      if (c) m_err = 1'b1;
      if (v) begin
        m_shadow[m_idx] = d;
        m_idx++;
        if (m_idx == N_OUT) m_full = 1'b1;
      end
    end
    #1;
    bus.io_cfg_valid  = 1'b0;
    bus.io_cfg_commit = 1'b0;
  endtask

  task automatic cyc(input bit v, input int d, input bit c, input logic [N_IN-1:0] xin);
    logic [N_OUT-1:0] g, e;
    drive_cycle(v, d, c, xin, g, e);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    model_reset();
    bus.io_xbar_in = 20'h00001;
    #3;
    n_checks++;
    if (bus.io_xbar_out !== exp_out()) begin
      n_errors++;
      $display("FAIL reset_out_in_reset got %h exp %h", bus.io_xbar_out, exp_out());
    end
    @(negedge clk);
    reset = 1'b1;
    cyc(0, 0, 0, 20'h00001);
    cyc(0, 0, 0, 20'h00001);
    n_checks++;
    if (bus.io_xbar_out !== 25'h1FFFFFF) begin
      n_errors++;
      $display("FAIL reset_out_ones got %h exp %h", bus.io_xbar_out, 25'h1FFFFFF);
    end
    cyc(0, 0, 0, 20'hFFFFE);
    cyc(0, 0, 0, 20'hFFFFE);
    n_checks++;
    if (bus.io_xbar_out !== 25'h0) begin
      n_errors++;
      $display("FAIL reset_out_zero got %h exp 0", bus.io_xbar_out);
    end
    n_checks++;
    if (got_status() !== {1'b1, 1'b0, 1'b0, CNT_W'(0)}) begin
      n_errors++;
      $display("FAIL reset_status got %h exp %h", got_status(), {1'b1, 1'b0, 1'b0, CNT_W'(0)});
    end
  endtask

  task automatic test_load_commit();
    for (int k = 0; k < N_OUT; k++) begin
      cyc(1, k % N_IN, 0, N_IN'($urandom));
      n_checks++;
      if (bus.io_xbar_out !== exp_out() || got_status() !== exp_status()) begin
        n_errors++;
        $display("FAIL load_word%0d out %h/%h status %h/%h", k,
                 bus.io_xbar_out, exp_out(), got_status(), exp_status());
      end
    end
    n_checks++;
    if (got_status() !== {1'b0, 1'b1, 1'b0, CNT_W'(N_OUT)}) begin
      n_errors++;
      $display("FAIL load_full_status got %h exp %h", got_status(), {1'b0, 1'b1, 1'b0, CNT_W'(N_OUT)});
    end
    cyc(0, 0, 1, N_IN'($urandom));
    cyc(0, 0, 0, 20'h00004);
    cyc(0, 0, 0, 20'h00004);
    n_checks++;
    if (bus.io_xbar_out !== 25'h0400004) begin
      n_errors++;
      $display("FAIL commit_route got %h exp %h", bus.io_xbar_out, 25'h0400004);
    end
    n_checks++;
    if (got_status() !== {1'b1, 1'b0, 1'b0, CNT_W'(0)}) begin
      n_errors++;
      $display("FAIL commit_status got %h exp %h", got_status(), {1'b1, 1'b0, 1'b0, CNT_W'(0)});
    end
  endtask

  task automatic test_out_of_range();
    for (int k = 0; k < N_OUT; k++)
      cyc(1, (k == 5) ? 31 : (k == 6) ? 20 : 0, 0, 20'hFFFFF);
    cyc(0, 0, 1, 20'hFFFFF);
    cyc(0, 0, 0, 20'hFFFFF);
    cyc(0, 0, 0, 20'hFFFFF);
    n_checks++;
    if (bus.io_xbar_out !== 25'h1FFFF9F) begin
      n_errors++;
      $display("FAIL out_of_range got %h exp %h", bus.io_xbar_out, 25'h1FFFF9F);
    end
  endtask

  task automatic test_illegal_commit();
    for (int k = 0; k < 10; k++) cyc(1, $urandom_range(0, 31), 0, N_IN'($urandom));
    cyc(0, 0, 1, N_IN'($urandom));
    n_checks++;
    if (got_status() !== {1'b1, 1'b0, 1'b1, CNT_W'(10)} || bus.io_xbar_out !== exp_out()) begin
      n_errors++;
      $display("FAIL illegal_commit_err status %h exp %h out %h exp %h",
               got_status(), {1'b1, 1'b0, 1'b1, CNT_W'(10)}, bus.io_xbar_out, exp_out());
    end
    cyc(0, 0, 0, N_IN'($urandom));
    n_checks++;
    if (got_status() !== {1'b1, 1'b0, 1'b0, CNT_W'(10)}) begin
      n_errors++;
      $display("FAIL illegal_commit_pulse got %h exp %h", got_status(), {1'b1, 1'b0, 1'b0, CNT_W'(10)});
    end
    for (int k = 10; k < N_OUT; k++) cyc(1, $urandom_range(0, 31), 0, N_IN'($urandom));
    n_checks++;
    if (got_status() !== {1'b0, 1'b1, 1'b0, CNT_W'(N_OUT)}) begin
      n_errors++;
      $display("FAIL illegal_commit_refill got %h exp %h", got_status(), {1'b0, 1'b1, 1'b0, CNT_W'(N_OUT)});
    end
    cyc(0, 0, 1, N_IN'($urandom));
  endtask

  task automatic test_async_reset();
    for (int k = 0; k < 12; k++) cyc(1, $urandom_range(0, 31), 0, N_IN'($urandom));
    @(negedge clk);
    bus.io_xbar_in = 20'h00001;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bus.io_xbar_out !== exp_out() || got_status() !== exp_status()) begin
      n_errors++;
      $display("FAIL async_reset out %h/%h status %h/%h",
               bus.io_xbar_out, exp_out(), got_status(), exp_status());
    end
    @(negedge clk);
    reset = 1'b1;
    for (int k = 0; k < N_OUT; k++) cyc(1, $urandom_range(0, N_IN - 1), 0, N_IN'($urandom));
    cyc(0, 0, 1, N_IN'($urandom));
    for (int i = 0; i < 4; i++) begin
      cyc(0, 0, 0, N_IN'($urandom));
      n_checks++;
      if (bus.io_xbar_out !== exp_out()) begin
        n_errors++;
        $display("FAIL post_reset_route got %h exp %h", bus.io_xbar_out, exp_out());
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int k = 0; k < N_OUT - 1; k++) cyc(1, $urandom_range(0, 31), 0, N_IN'($urandom));
    cyc(1, 3, 1, N_IN'($urandom));
    n_checks++;
    if (got_status() !== {1'b0, 1'b1, 1'b1, CNT_W'(N_OUT)} || bus.io_xbar_out !== exp_out()) begin
      n_errors++;
      $display("FAIL last_word_commit status %h exp %h out %h exp %h",
               got_status(), {1'b0, 1'b1, 1'b1, CNT_W'(N_OUT)}, bus.io_xbar_out, exp_out());
    end
    cyc(1, 7, 1, N_IN'($urandom));
    n_checks++;
    if (got_status() !== {1'b1, 1'b0, 1'b0, CNT_W'(0)} || bus.io_xbar_out !== exp_out()) begin
      n_errors++;
      $display("FAIL full_commit_valid status %h exp %h out %h exp %h",
               got_status(), {1'b1, 1'b0, 1'b0, CNT_W'(0)}, bus.io_xbar_out, exp_out());
    end
  endtask

  task automatic test_random();
    logic [N_OUT-1:0] mid_got, mid_exp;
    for (int i = 0; i < 600; i++) begin
      drive_cycle(bit'($urandom_range(0, 1)), $urandom_range(0, 31),
                  ($urandom_range(0, 11) == 0), N_IN'($urandom), mid_got, mid_exp);
      n_checks++;
      if (mid_got !== mid_exp || bus.io_xbar_out !== exp_out() || got_status() !== exp_status()) begin
        n_errors++;
        $display("FAIL random_cycle%0d mid %h/%h out %h/%h status %h/%h", i, mid_got, mid_exp,
                 bus.io_xbar_out, exp_out(), got_status(), exp_status());
      end
    end
  endtask

  initial begin
    bus.io_cfg_valid  = 1'b0;
    bus.io_cfg_data   = '0;
    bus.io_cfg_commit = 1'b0;
    bus.io_xbar_in    = '0;
    test_reset();
    test_load_commit();
    test_out_of_range();
    test_illegal_commit();
    test_async_reset();
    test_simultaneous();
    test_random();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/xbar_cfg.md
Name: xbar_cfg

Overview:
- Parametrised successor to the fixed 20-in/25-out LUT-tile crossbar.
- Each of N_OUT outputs selects one of N_IN inputs through a per-output select field.
- Select fields are double-buffered: a shadow bank is loaded word-serially through a valid/ready port, then copied atomically into the active bank by a commit strobe.
- The crossbar can therefore be reprogrammed while live traffic sees only old or new routing, never a mix.
- Sits between tile input routing and LUT input pins.

Parameters:
- N_IN, 20, number of crossbar inputs (>=2).
- N_OUT, 25, number of crossbar outputs (>=1).
- SEL_W, 5, select field width; must satisfy 2**SEL_W >= N_IN.
- CNT_W, 5, load index counter width; must satisfy 2**CNT_W > N_OUT.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted); deassertion synchronous to clk externally.
- io_xbar_in  input  N_IN  data inputs.
- io_xbar_out  output  N_OUT  routed outputs.
- io_cfg_valid  input  1  config word offered.
- io_cfg_ready  output  1  shadow bank can accept a word.
- io_cfg_data  input  SEL_W  select value for the next output index.
- io_cfg_commit  input  1  single-cycle request to copy shadow to active.
- io_cfg_full  output  1  all N_OUT shadow words loaded, awaiting commit.
- io_cfg_err  output  1  one-cycle pulse on an illegal commit.
- io_cfg_idx  output  CNT_W  index of the next shadow word to be written.

Behaviour:
- Storage:
  - shadow[N_OUT][SEL_W] and active[N_OUT][SEL_W].
  - Load counter idx, 0..N_OUT.
- Routing (combinational from active and io_xbar_in):
  - io_xbar_out[k] = io_xbar_in[active[k]] when active[k] < N_IN.
  - io_xbar_out[k] = 0 when active[k] >= N_IN (out-of-range select drives 0; never X).
- Reset, asynchronous while reset == 0:
  - active, shadow and idx all 0, so every output follows io_xbar_in[0].
  - io_cfg_ready = 1, io_cfg_full = 0, io_cfg_err = 0, state LOAD.
- FSM states: LOAD, FULL.
  - LOAD:
    - io_cfg_ready = 1.
    - Handshake (valid & ready) writes shadow[idx] <= io_cfg_data, then idx <= idx+1.
    - Accepting the word at idx == N_OUT-1 moves to FULL next cycle; idx becomes N_OUT.
  - FULL:
    - io_cfg_ready = 0 and io_cfg_full = 1; io_cfg_valid is ignored.
    - io_cfg_commit: active <= shadow (all fields in the same edge), idx <= 0, go to LOAD.
    - New routing is visible on io_xbar_out the cycle after the commit edge.
    - Shadow contents are retained after commit, but every word must be rewritten before the next commit.
- Illegal commit:
  - io_cfg_commit asserted in LOAD (including mid-load) causes io_cfg_err = 1 for exactly one cycle.
  - active is unchanged; idx and shadow are unchanged, so loading continues.
- Simultaneous events:
  - Commit in FULL with valid high: commit taken, word not accepted (ready was 0).
  - Commit in LOAD on the same cycle as the final word handshake: the word is accepted, err pulses, state goes to FULL, no copy.
- Reset mid-load or while FULL: partial shadow discarded (zeroed), active reverts to all-zero selects.
- io_cfg_idx reflects idx directly; its value is N_OUT in FULL.
- Latency:
  - Data path is 0 cycles (combinational).
  - Commit-to-route is 1 clock.

Optional Feature:
- Macro XBAR_CFG_OUT_REG_EN.
- Defined:
  - io_xbar_out is registered: a flop per output captures the routed value.
  - Data latency becomes 1 cycle; commit-to-route becomes 2 cycles.
  - Output flops reset to 0 asynchronously.
- Undefined:
  - Purely combinational output path as specified above.
  - No extra flops.

Test Plan:
- Reset, then io_xbar_in = 20'h00001 → all 25 outputs = 1; io_xbar_in = 20'hFFFFE → all outputs = 0; ready = 1, full = 0, idx = 0.
- Load shadow[k] = k mod 20 for k = 0..24 with valid held high → full rises after the 25th handshake; idx = 25; outputs unchanged until commit. After commit, io_xbar_in = 20'h00004 → io_xbar_out[2] = 1, io_xbar_out[22] = 1, all others 0; idx = 0, ready = 1.
- Load words at k = 5 set to 31 and k = 6 set to 20, others 0; commit → out[5] = 0 and out[6] = 0 for io_xbar_in = 20'hFFFFF; all other outputs = 1.
- Commit pulsed after 10 words → err high for exactly 1 cycle; routing unchanged; idx stays 10. The remaining 15 words then load normally and full asserts.
- Assert reset (0) asynchronously mid-cycle after 12 words → outputs immediately follow io_xbar_in[0]; idx = 0; full = 0. A subsequent full load and commit works.
- With XBAR_CFG_OUT_REG_EN defined, toggle io_xbar_in[0] → io_xbar_out[0] follows exactly one clock later. Commit → new routing appears 2 clocks after the commit edge.
